// File: rtl/trace_stim_gen_if.sv
// ---------------------------------------------------------------------------
// trace_stim_gen_if
//
// PowerPC instruction-trace bus between a trace source (the CPU, or the
// trace_stim_gen self-test generator) and a trace consumer (the function
// profiler).
//
// Signals:
//   P_Trace_Instruction  [0:31]  instruction word, bit 0 is the MSB
//   P_Trace_Valid_Instr  1       word is valid this cycle
//
// Modports:
//   master  drives the trace (generator / CPU side)
//   slave   observes the trace (profiler side)
// ---------------------------------------------------------------------------
interface trace_stim_gen_if;

    logic [0:31] P_Trace_Instruction;
    logic        P_Trace_Valid_Instr;

    modport master (
        output P_Trace_Instruction,
        output P_Trace_Valid_Instr
    );

    modport slave (
        input P_Trace_Instruction,
        input P_Trace_Valid_Instr
    );

endinterface

// File: rtl/trace_stim_gen.sv
// ---------------------------------------------------------------------------
// trace_stim_gen
//
// Synthesises a PowerPC instruction-trace stream containing programmable
// call/return sequences. It stands in for the CPU on the profiler's trace
// inputs during on-board self-test and bring-up, and reports reference values
// (span of the last call, number of calls) so software can cross-check the
// profiler's measurements.
//
// Each run consists of repeat_count iterations of
//   pre_len NOPs -> bl -> body_len NOPs -> blr
// optionally with a bubble (invalid cycle) after every STALL_EVERY valid beats.
//
// Parameters:
//   STALL_EVERY  bubble after this many valid beats; 0 disables bubbles
//   CALL_LI      24-bit LI field of the emitted bl word
//   CNT_W        width of call_count
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   start         begin a run (only honoured while idle)
//   abort         synchronous run termination, no done pulse
//   pre_len       NOP beats before each call
//   body_len      NOP beats between call and return
//   repeat_count  iterations per run, 0 behaves as 1
//   busy          run in progress (beats or bubbles being emitted)
//   done          one-cycle pulse when a run completes normally
//   trace         trace bus (master side)
//   span_cycles   cycles from after the last bl beat up to its blr beat
//   call_count    bl beats emitted since reset, wrapping
// ---------------------------------------------------------------------------
module trace_stim_gen #(
    parameter int unsigned STALL_EVERY = 0,
    parameter logic [23:0] CALL_LI     = 24'h000010,
    parameter int          CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          pre_len,
    input  logic [15:0]          body_len,
    input  logic [7:0]           repeat_count,
    output logic                 busy,
    output logic                 done,
    trace_stim_gen_if.master     trace,
    output logic [31:0]          span_cycles,
    output logic [CNT_W-1:0]     call_count
);

    localparam logic [31:0] NOP_WORD  = 32'h6000_0000;
    localparam logic [31:0] CALL_WORD = {6'd18, CALL_LI, 2'b01};
    localparam logic [31:0] RET_WORD  = 32'h4E80_0020;

    // The state names the beat that will be presented at the next clock edge,
    // so the registered outputs always line up with the state they came from.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CALL,
        S_BODY,
        S_RET,
        S_FIN
    } state_t;

    state_t      state_q, state_n;

    logic [15:0] pre_q, pre_n;
    logic [15:0] body_q, body_n;
    logic [7:0]  iter_q, iter_n;
    logic [15:0] beat_q, beat_n;
    logic [15:0] stall_q, stall_n;
    logic [31:0] span_run_q, span_run_n;

    logic [0:31]      word_q, word_n;
    logic             valid_q, valid_n;
    logic             busy_n;
    logic             done_n;
    logic [31:0]      span_n;
    logic [CNT_W-1:0] calls_n;

    logic             stall_hit;

    // A bubble replaces the next beat once STALL_EVERY valid beats have gone out.
    assign stall_hit = (STALL_EVERY != 0) && ({16'd0, stall_q} == STALL_EVERY);

    assign trace.P_Trace_Instruction = word_q;
    assign trace.P_Trace_Valid_Instr = valid_q;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            body_q      <= '0;
            iter_q      <= '0;
            beat_q      <= '0;
            stall_q     <= '0;
            span_run_q  <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            span_cycles <= '0;
            call_count  <= '0;
        end else begin
            state_q     <= state_n;
            pre_q       <= pre_n;
            body_q      <= body_n;
            iter_q      <= iter_n;
            beat_q      <= beat_n;
            stall_q     <= stall_n;
            span_run_q  <= span_run_n;
            word_q      <= word_n;
            valid_q     <= valid_n;
            busy        <= busy_n;
            done        <= done_n;
            span_cycles <= span_n;
            call_count  <= calls_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state_q;
        pre_n      = pre_q;
        body_n     = body_q;
        iter_n     = iter_q;
        beat_n     = beat_q;
        stall_n    = stall_q;
        span_run_n = span_run_q;
        word_n     = '0;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        span_n     = span_cycles;
        calls_n    = call_count;

        if (state_q == S_IDLE) begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
                pre_n   = pre_len;
                body_n  = body_len;
                iter_n  = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                beat_n  = '0;
                stall_n = '0;
                state_n = (pre_len != 16'd0) ? S_PRE : S_CALL;
            end
        end else if (abort) begin
            beat_n  = '0;
            state_n = S_IDLE;
        end else if (state_q == S_FIN) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
        end else begin
            busy_n     = 1'b1;
            // Runs through bubbles too; the bl beat restarts it below.
            span_run_n = span_run_q + 32'd1;

            if (stall_hit) begin
                // Bubble: nothing advances except the span counter.
                stall_n = '0;
            end else begin
                valid_n = 1'b1;
                stall_n = stall_q + 16'd1;

                unique case (state_q)
                    S_PRE: begin
                        word_n = NOP_WORD;
                        if (beat_q == pre_q - 16'd1) begin
                            beat_n  = '0;
                            state_n = S_CALL;
                        end else begin
                            beat_n = beat_q + 16'd1;
                        end
                    end
                    S_CALL: begin
                        word_n     = CALL_WORD;
                        calls_n    = call_count + CNT_W'(1);
                        span_run_n = '0;
                        state_n    = (body_q != 16'd0) ? S_BODY : S_RET;
                    end
                    S_BODY: begin
                        word_n = NOP_WORD;
                        if (beat_q == body_q - 16'd1) begin
                            beat_n  = '0;
                            state_n = S_RET;
                        end else begin
                            beat_n = beat_q + 16'd1;
                        end
                    end
                    S_RET: begin
                        word_n = RET_WORD;
                        span_n = span_run_q + 32'd1;
                        if (iter_q <= 8'd1) begin
                            state_n = S_FIN;
                        end else begin
                            iter_n  = iter_q - 8'd1;
                            state_n = (pre_q != 16'd0) ? S_PRE : S_CALL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/trace_stim_gen.md
Name: trace_stim_gen

Overview:
- Transmitter side of the processor instruction-trace interface: synthesises a PowerPC trace stream (P_Trace_Instruction / P_Trace_Valid_Instr) that contains programmable call/return sequences.
- Drives the trace inputs of the function profiler in place of the CPU, for on-board self-test and bring-up.
- Reports reference values so software can check the profiler's count against a known span.

Parameters:
- STALL_EVERY, 0, insert one invalid (bubble) cycle after every STALL_EVERY valid beats; 0 = never stall
- CALL_LI, 24'h000010, 24-bit LI field placed in the emitted bl word
- CNT_W, 16, width of call_count

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous; terminate the run, return to IDLE
- pre_len  in  16  NOP beats before each call
- body_len  in  16  NOP beats between call and return
- repeat_count  in  8  iterations per run; 0 is treated as 1
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- P_Trace_Instruction  out  [0:31]  instruction word, bit 0 = MSB
- P_Trace_Valid_Instr  out  1  word valid this cycle
- span_cycles  out  32  cycles from the cycle after the last CALL beat through its RET beat, inclusive
- call_count  out  CNT_W  total bl beats emitted since reset

Behaviour:
- Encodings:
  - NOP = 32'h60000000
  - CALL (bl) = {6'd18, CALL_LI, 2'b01}
  - RET (blr) = 32'h4E800020
  - bubble / idle = valid 0, word 32'h00000000
- All outputs are registered. On reset: state IDLE; busy = 0, done = 0, valid = 0, word = 0, span_cycles = 0, call_count = 0; stall counter and iteration counter = 0.
- States: IDLE, PRE, CALL, BODY, RET, FIN.
- IDLE:
  - If start = 1 at edge k: latch pre_len, body_len and repeat_count; clear the stall counter.
  - At edge k+1: busy = 1, and the first beat is presented in that cycle.
  - start is ignored outside IDLE.
- Each iteration runs PRE (pre_len NOP beats) -> CALL (1 beat) -> BODY (body_len NOP beats) -> RET (1 beat).
  - A zero-length PRE or BODY is skipped; there is no empty cycle.
- After RET: if iterations remain, go to PRE; otherwise go to FIN.
  - FIN lasts one cycle: done = 1, busy = 0, valid = 0.
  - Then return to IDLE.
- Stalls (STALL_EVERY > 0):
  - The stall counter counts valid beats.
  - When it reaches STALL_EVERY, the next cycle is a bubble and the counter clears.
  - State and beat counters do not advance during a bubble.
  - Bubbles can fall anywhere, including between CALL and the first BODY beat, or immediately before RET.
  - The counter persists across iterations within a run.
- span_cycles:
  - An internal counter clears on the CALL beat and increments every cycle after it (bubbles included), up to and including the RET beat.
  - span_cycles loads this value on the RET beat, so it equals body_len + 1 + bubbles in that window.
  - It holds until the next RET.
- call_count increments on each CALL beat and wraps at 2^CNT_W.
- abort = 1 in any non-IDLE state:
  - Next cycle: IDLE, valid = 0, word = 0, busy = 0.
  - No done pulse.
  - span_cycles and call_count keep their current values.
  - abort takes priority over the state advance.
- Asynchronous reset mid-run forces the reset values immediately, with no done pulse.
- start and abort asserted together in IDLE: abort wins and the run does not start.

Test Plan:
- STALL_EVERY = 0; pre_len = 2, body_len = 3, repeat = 1, start pulse:
  - Valid beats NOP, NOP, CALL(48000041), NOP x3, 4E800020.
  - Then done pulse; busy high for 7 cycles.
  - span_cycles = 4, call_count = 1.
- pre_len = 0, body_len = 0, repeat = 3: stream is CALL, RET, CALL, RET, CALL, RET back-to-back; span_cycles = 1; call_count = 3.
- STALL_EVERY = 2; pre_len = 0, body_len = 4:
  - Valid pattern 1,1,0,1,1,0,1,1 (CALL, NOP, bubble, NOP, NOP, bubble, NOP, RET).
  - span_cycles = 7.
- abort asserted on the 2nd BODY beat: next cycle valid = 0, busy = 0, no done; a subsequent start runs normally from PRE.
- repeat_count = 0 and start held high for 10 cycles: exactly one iteration runs; start is ignored while busy; done pulses once.
- Reset asserted asynchronously mid-BODY: all outputs go to 0 immediately; call_count = 0 after release.
